// File: rtl/edge_pkg.sv
// Shared types and constants for the Sobel frame sequencer.
// EDGE_BORDER_ZERO_EN adds the BORDER state, which zero-fills the frame border.
package edge_pkg;

  localparam int unsigned FrameCntW = 16;

  typedef logic [3:0] pix_t;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StClear  = 3'd1,
    StRead   = 3'd2,
    StDrain  = 3'd3,
`ifdef EDGE_BORDER_ZERO_EN
    StBorder = 3'd4,
`endif
    StDone   = 3'd5
  } state_e;

  // Number of pixels on the outer ring of a w x h frame.
  function automatic int unsigned border_count(input int unsigned w, input int unsigned h);
    return 2 * w + 2 * h - 4;
  endfunction

endpackage

// File: rtl/border_addr_gen.sv
// Walks the border pixels: row 0, row H-1, then (y,0)/(y,W-1) for y=1..H-2.
// Instantiated only when EDGE_BORDER_ZERO_EN is defined.
module border_addr_gen
  import edge_pkg::*;
#(
  parameter int unsigned IMG_W  = 640,
  parameter int unsigned IMG_H  = 480,
  parameter int unsigned ADDR_W = $clog2(IMG_W * IMG_H)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              step,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  localparam int unsigned BCount = border_count(IMG_W, IMG_H);
  localparam int unsigned CntW   = $clog2(BCount);

  localparam logic [ADDR_W-1:0] TopEnd      = ADDR_W'(IMG_W - 1);
  localparam logic [ADDR_W-1:0] BottomBase  = ADDR_W'((IMG_H - 1) * IMG_W);
  localparam logic [ADDR_W-1:0] BottomEnd   = ADDR_W'(IMG_H * IMG_W - 1);
  localparam logic [ADDR_W-1:0] RowStep     = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] RightOffset = ADDR_W'(IMG_W - 1);

  typedef enum logic [1:0] {PhTop, PhBottom, PhSides} phase_e;

  phase_e            ph_q, ph_d;
  logic              side_q, side_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  always_comb begin
    ph_d   = ph_q;
    side_d = side_q;
    addr_d = addr_q;
    cnt_d  = cnt_q;
    if (start) begin
      ph_d   = PhTop;
      side_d = 1'b0;
      addr_d = '0;
      cnt_d  = '0;
    end else if (step) begin
      cnt_d = cnt_q + 1'b1;
      unique case (ph_q)
        PhTop: begin
          if (addr_q == TopEnd) begin
            ph_d   = PhBottom;
            addr_d = BottomBase;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
        PhBottom: begin
          if (addr_q == BottomEnd) begin
            ph_d   = PhSides;
            side_d = 1'b0;
            addr_d = RowStep;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
        PhSides: begin
          // Left edge hops to the right edge of the same row, right edge to the next row start.
          if (!side_q) begin
            addr_d = addr_q + RightOffset;
            side_d = 1'b1;
          end else begin
            addr_d = addr_q + 1'b1;
            side_d = 1'b0;
          end
        end
        default: ph_d = PhTop;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ph_q   <= PhTop;
      side_q <= 1'b0;
      addr_q <= '0;
      cnt_q  <= '0;
    end else begin
      ph_q   <= ph_d;
      side_q <= side_d;
      addr_q <= addr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign addr = addr_q;
  assign last = (cnt_q == CntW'(BCount - 1));

endmodule

// File: rtl/edge_frame_ctrl.sv
// Frame sequencer: streams a frame from source RAM into the Sobel filter and writes
// interior results to destination RAM. EDGE_BORDER_ZERO_EN also zero-fills the border.
module edge_frame_ctrl
  import edge_pkg::*;
#(
  parameter int unsigned IMG_W  = 640,
  parameter int unsigned IMG_H  = 480,
  parameter int unsigned ADDR_W = $clog2(IMG_W * IMG_H)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 hold,
  output logic                 busy,
  output logic                 done,
  output logic [FrameCntW-1:0] frame_cnt,
  output logic                 src_rd_en,
  output logic [ADDR_W-1:0]    src_addr,
  input  pix_t                 src_data,
  output logic                 filt_clr,
  output logic                 filt_in_ready,
  output pix_t                 filt_pixel,
  input  pix_t                 filt_pixel_out,
  output logic                 dst_wr_en,
  output logic [ADDR_W-1:0]    dst_addr,
  output pix_t                 dst_data
);

  localparam int unsigned XW = $clog2(IMG_W);
  localparam int unsigned YW = $clog2(IMG_H);

  localparam logic [XW-1:0]     XLast   = XW'(IMG_W - 1);
  localparam logic [YW-1:0]     YLast   = YW'(IMG_H - 1);
  localparam logic [ADDR_W-1:0] RowStep = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] DiagOff = ADDR_W'(IMG_W + 1);

  state_e            state_q, state_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [1:0]        drain_q, drain_d;
  logic [FrameCntW-1:0] frame_cnt_q;

  logic              rd_en;
  logic              brd_wr;
  logic [ADDR_W-1:0] brd_wr_addr;

  // Pipeline: strobe stage (pixel in filter), capture stage (filter output valid), write stage.
  logic              strb_q, strb_int_q;
  logic [ADDR_W-1:0] strb_addr_q;
  logic              pend_q;
  logic [ADDR_W-1:0] pend_addr_q;
  logic              wr_q;
  logic [ADDR_W-1:0] wr_addr_q;
  pix_t              wr_data_q;

`ifdef EDGE_BORDER_ZERO_EN
  logic              brd_start, brd_step, brd_last;
  logic              bdone_q, bdone_d;
  logic [ADDR_W-1:0] brd_addr;

  border_addr_gen #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .ADDR_W(ADDR_W)
  ) u_border_addr_gen (
    .clk  (clk),
    .rst  (rst),
    .start(brd_start),
    .step (brd_step),
    .addr (brd_addr),
    .last (brd_last)
  );
`endif

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    base_d      = base_q;
    drain_d     = drain_q;
    rd_en       = 1'b0;
    brd_wr      = 1'b0;
    brd_wr_addr = '0;
`ifdef EDGE_BORDER_ZERO_EN
    brd_start   = 1'b0;
    brd_step    = 1'b0;
    bdone_d     = bdone_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start && !abort) state_d = StClear;
      end
      StClear: begin
        x_d     = '0;
        y_d     = '0;
        base_d  = '0;
        state_d = StRead;
      end
      StRead: begin
        if (!hold) begin
          rd_en = 1'b1;
          if (x_q == XLast) begin
            x_d = '0;
            if (y_q == YLast) begin
              drain_d = '0;
              state_d = StDrain;
            end else begin
              y_d    = y_q + 1'b1;
              base_d = base_q + RowStep;
            end
          end else begin
            x_d = x_q + 1'b1;
          end
        end
      end
      StDrain: begin
        drain_d = drain_q + 1'b1;
        if (drain_q == 2'd2) begin
`ifdef EDGE_BORDER_ZERO_EN
          brd_start = 1'b1;
          bdone_d   = 1'b0;
          state_d   = StBorder;
`else
          state_d   = StDone;
`endif
        end
      end
`ifdef EDGE_BORDER_ZERO_EN
      StBorder: begin
        // Final cycle issues nothing so the last border write lands before DONE.
        if (bdone_q) begin
          state_d = StDone;
        end else begin
          brd_wr      = 1'b1;
          brd_wr_addr = brd_addr;
          brd_step    = 1'b1;
          if (brd_last) bdone_d = 1'b1;
        end
      end
`endif
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (abort && state_q != StIdle) state_d = StIdle;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      x_q         <= '0;
      y_q         <= '0;
      base_q      <= '0;
      drain_q     <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      base_q  <= base_d;
      drain_q <= drain_d;
      if (done) frame_cnt_q <= frame_cnt_q + 1'b1;
    end
  end

`ifdef EDGE_BORDER_ZERO_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) bdone_q <= 1'b0;
    else     bdone_q <= bdone_d;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      strb_q      <= 1'b0;
      strb_int_q  <= 1'b0;
      strb_addr_q <= '0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      wr_q        <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      strb_q      <= rd_en && !abort;
      strb_int_q  <= (y_q >= YW'(2)) && (x_q >= XW'(2));
      strb_addr_q <= src_addr;
      pend_q      <= strb_q && strb_int_q && !abort;
      pend_addr_q <= strb_addr_q - DiagOff;
      wr_q        <= (pend_q || brd_wr) && !abort;
      wr_addr_q   <= brd_wr ? brd_wr_addr : pend_addr_q;
      wr_data_q   <= brd_wr ? '0 : filt_pixel_out;
    end
  end

  assign busy          = (state_q != StIdle);
  assign done          = (state_q == StDone) && !abort;
  assign frame_cnt     = frame_cnt_q;
  assign src_rd_en     = rd_en;
  assign src_addr      = base_q + ADDR_W'(x_q);
  assign filt_clr      = (state_q == StClear);
  assign filt_in_ready = strb_q;
  assign filt_pixel    = src_data;
  assign dst_wr_en     = wr_q;
  assign dst_addr      = wr_addr_q;
  assign dst_data      = wr_data_q;

endmodule

// File: tb/tb_edge_frame_ctrl.sv
// Randomized bench for edge_frame_ctrl on an 8x6 frame with a stand-in Sobel filter,
// source RAM and a frame-level reference model of writes, ordering and timing.
module tb_edge_frame_ctrl;

  localparam int W  = 8;
  localparam int H  = 6;
  localparam int N  = W * H;
  localparam int AW = $clog2(N);

  typedef logic [3:0] frame_t[N];
  typedef struct {
    int addr;
    int data;
    int cyc;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, abort, hold;
  logic          busy, done;
  logic [15:0]   frame_cnt;
  logic          src_rd_en;
  logic [AW-1:0] src_addr;
  logic [3:0]    src_data;
  logic          filt_clr, filt_in_ready;
  logic [3:0]    filt_pixel, filt_pixel_out;
  logic          dst_wr_en;
  logic [AW-1:0] dst_addr;
  logic [3:0]    dst_data;

  frame_t img;
  frame_t fbuf;
  int     fcnt;

  int  n_checks = 0;
  int  n_errors = 0;
  int  exp_frames = 0;
  wr_t wq[$];
  int  done_at, end_at, clr_at, rd_at, n_clr, n_done;

  edge_frame_ctrl #(
    .IMG_W(W),
    .IMG_H(H)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .abort         (abort),
    .hold          (hold),
    .busy          (busy),
    .done          (done),
    .frame_cnt     (frame_cnt),
    .src_rd_en     (src_rd_en),
    .src_addr      (src_addr),
    .src_data      (src_data),
    .filt_clr      (filt_clr),
    .filt_in_ready (filt_in_ready),
    .filt_pixel    (filt_pixel),
    .filt_pixel_out(filt_pixel_out),
    .dst_wr_en     (dst_wr_en),
    .dst_addr      (dst_addr),
    .dst_data      (dst_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int px(input frame_t f, input int y, input int x);
    return int'(f[y * W + x]);
  endfunction

  // Sobel |Gx|+|Gy| saturated to 4 bits, centred on (cy,cx).
  function automatic int sobel_at(input frame_t f, input int cy, input int cx);
    int gx, gy, m;
    gx = px(f, cy - 1, cx + 1) + 2 * px(f, cy, cx + 1) + px(f, cy + 1, cx + 1)
       - px(f, cy - 1, cx - 1) - 2 * px(f, cy, cx - 1) - px(f, cy + 1, cx - 1);
    gy = px(f, cy + 1, cx - 1) + 2 * px(f, cy + 1, cx) + px(f, cy + 1, cx + 1)
       - px(f, cy - 1, cx - 1) - 2 * px(f, cy - 1, cx) - px(f, cy - 1, cx + 1);
    m = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    return (m > 15) ? 15 : m;
  endfunction

  // Stand-in filter output: window whose bottom-right is the latest strobed pixel.
  function automatic logic [3:0] filt_window(input frame_t f, input int cnt);
    int p;
    p = cnt - 1;
    if (cnt <= 0 || cnt > N) return 4'd0;
    if (p / W >= 2 && p % W >= 2) return 4'(sobel_at(f, p / W - 1, p % W - 1));
    return 4'd0;
  endfunction

  always_comb filt_pixel_out = filt_window(fbuf, fcnt);

  always @(posedge clk) begin
    if (rst || filt_clr) begin
      fcnt <= 0;
    end else if (filt_in_ready && fcnt < N) begin
      fbuf[fcnt] <= filt_pixel;
      fcnt       <= fcnt + 1;
    end
  end

  always @(posedge clk) begin
    if (rst) src_data <= 4'd0;
    else if (src_rd_en) src_data <= img[src_addr];
  end

  // Cycle in which the n-th pixel is read, counting cycles after the start edge from 1.
  function automatic int read_cycle(input int n, input int hf, input int ht);
    int cnt;
    cnt = 0;
    for (int c = 2; c < 10000; c++) begin
      if (c >= hf && c <= ht) continue;
      if (cnt == n) return c;
      cnt++;
    end
    return -1;
  endfunction

  function automatic int border_len();
`ifdef EDGE_BORDER_ZERO_EN
    return 2 * W + 2 * H - 4;
`else
    return 0;
`endif
  endfunction

  task automatic run_frame(input int hf, input int ht, input int abort_at, input bit start_mid);
    wq.delete();
    done_at = -1;
    end_at  = -1;
    clr_at  = -1;
    rd_at   = -1;
    n_clr   = 0;
    n_done  = 0;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      hold  = (cyc >= hf && cyc <= ht);
      abort = (cyc == abort_at);
      start = start_mid && (cyc == 20);
      @(negedge clk);
      if (filt_clr) begin
        n_clr++;
        if (clr_at < 0) clr_at = cyc;
      end
      if (src_rd_en && rd_at < 0) rd_at = cyc;
      if (dst_wr_en) wq.push_back('{int'(dst_addr), int'(dst_data), cyc});
      if (done) begin
        n_done++;
        done_at = cyc;
      end
      if (!busy) begin
        end_at = cyc;
        check("end_idle_wr", dst_wr_en, 1'b0);
        break;
      end
      @(posedge clk);
      #1;
    end
    if (end_at < 0) check("timeout_busy", busy, 1'b0);
    hold  = 1'b0;
    abort = 1'b0;
    start = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic eval_frame(input string name, input int hf, input int ht);
    int ni, nb, ey, ex, eaddr, ecyc, bi;
    int bseq[$];
    bit seen[N];
    ni = (H - 2) * (W - 2);
    nb = border_len();
    for (int x = 0; x < W; x++) bseq.push_back(x);
    for (int x = 0; x < W; x++) bseq.push_back((H - 1) * W + x);
    for (int y = 1; y < H - 1; y++) begin
      bseq.push_back(y * W);
      bseq.push_back(y * W + W - 1);
    end
    exp_frames++;
    check($sformatf("%s_clr_cycle", name), clr_at, 1);
    check($sformatf("%s_clr_count", name), n_clr, 1);
    check($sformatf("%s_first_read", name), rd_at, read_cycle(0, hf, ht));
    check($sformatf("%s_num_writes", name), wq.size(), ni + nb);
    foreach (wq[i]) begin
      if (wq[i].addr < N) begin
        check($sformatf("%s_dup_addr%0d", name, wq[i].addr), seen[wq[i].addr], 1'b0);
        seen[wq[i].addr] = 1'b1;
      end
      if (i < ni) begin
        ey    = 1 + i / (W - 2);
        ex    = 1 + i % (W - 2);
        eaddr = ey * W + ex;
        ecyc  = read_cycle((ey + 1) * W + ex + 1, hf, ht) + 3;
        check($sformatf("%s_wr%0d_addr", name, i), wq[i].addr, eaddr);
        check($sformatf("%s_wr%0d_data", name, i), wq[i].data, sobel_at(img, ey, ex));
        check($sformatf("%s_wr%0d_cycle", name, i), wq[i].cyc, ecyc);
      end else if (i < ni + nb) begin
        bi = i - ni;
        check($sformatf("%s_brd%0d_addr", name, bi), wq[i].addr, bseq[bi]);
        check($sformatf("%s_brd%0d_data", name, bi), wq[i].data, 0);
      end
    end
    check($sformatf("%s_done_count", name), n_done, 1);
    check($sformatf("%s_done_cycle", name), done_at,
          read_cycle(N - 1, hf, ht) + 4 + (nb > 0 ? nb + 1 : 0));
    check($sformatf("%s_busy_low", name), end_at, done_at + 1);
    check($sformatf("%s_frame_cnt", name), frame_cnt, exp_frames);
  endtask

  task automatic rand_image();
    for (int i = 0; i < N; i++) img[i] = 4'($urandom_range(0, 15));
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    hold  = 1'b0;
    for (int i = 0; i < N; i++) img[i] = 4'd5;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_frame_cnt", frame_cnt, 16'd0);
    check("rst_rd_en", src_rd_en, 1'b0);
    check("rst_wr_en", dst_wr_en, 1'b0);
    check("rst_clr", filt_clr, 1'b0);
    check("rst_strobe", filt_in_ready, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // start together with abort must not leave IDLE
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    check("start_abort_busy", busy, 1'b0);
    check("start_abort_clr", filt_clr, 1'b0);
    @(posedge clk);
    #1;

    run_frame(0, -1, -1, 1'b0);
    eval_frame("const5", 0, -1);

    rand_image();
    run_frame(0, -1, -1, 1'b0);
    eval_frame("rand", 0, -1);

    run_frame(10, 14, -1, 1'b0);
    eval_frame("hold", 10, 14);

    rand_image();
    run_frame(0, -1, 30, 1'b0);
    check("abort_busy_low", end_at, 31);
    check("abort_no_done", n_done, 0);
    check("abort_frame_cnt", frame_cnt, exp_frames);

    rand_image();
    run_frame(0, -1, -1, 1'b0);
    eval_frame("post_abort", 0, -1);

    rand_image();
    run_frame(0, -1, -1, 1'b1);
    eval_frame("b2b_first", 0, -1);
    run_frame(0, -1, -1, 1'b0);
    eval_frame("b2b_second", 0, -1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/edge_frame_ctrl.md
# edge_frame_ctrl

Frame sequencer for the Sobel edge filter. On `start` it clears the filter, streams one full frame from the source frame RAM into the filter, and writes the interior output pixels to the destination frame RAM at their centre-pixel addresses. Optionally it also writes zeros to the border pixels. It sits between the frame buffers and the edge filter, owns the filter's pixel strobe, and reports `busy`, `done` and a frame count to the system controller.

## Interface
- `IMG_W`, 640, frame width in pixels (≥3)
- `IMG_H`, 480, frame height in pixels (≥3)
- `ADDR_W`, `$clog2(IMG_W*IMG_H)`, linear pixel address width
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: one-cycle request to process a frame.
- `abort` in 1: cancel the current frame.
- `hold` in 1: pause source reads while in READ.
- `busy` out 1: high whenever the block is not in IDLE.
- `done` out 1: one-cycle pulse when a frame completes.
- `frame_cnt` out 16: number of completed frames; wraps modulo 2^16.
- `src_rd_en` out 1: source RAM read request.
- `src_addr` out ADDR_W: source read address.
- `src_data` in 4: source read data; valid one cycle after `src_rd_en`.
- `filt_clr` out 1: filter clear; system ORs this into the filter's `rst`.
- `filt_in_ready` out 1: filter pixel strobe.
- `filt_pixel` out 4: filter pixel input; equals `src_data`.
- `filt_pixel_out` in 4: filter result, combinational from the filter window.
- `dst_wr_en` out 1: destination RAM write enable.
- `dst_addr` out ADDR_W: destination write address.
- `dst_data` out 4: destination write data.

## Operation
- States: IDLE, CLEAR, READ, DRAIN, BORDER (only with the macro), DONE.
- IDLE:
  - `start`=1 with `abort`=0 → CLEAR.
  - `start` is ignored in every other state.
- CLEAR: one cycle with `filt_clr`=1 → READ. Source counters are reset to 0.
- READ:
  - Each cycle with `hold`=0, assert `src_rd_en` with `src_addr`=y·W+x, then advance x, and advance y when x wraps from W−1 to 0.
  - With `hold`=1, no read is issued and the counters hold.
  - After the read of address W·H−1 → DRAIN.
- Strobe: `filt_in_ready` is `src_rd_en` delayed one cycle. `filt_pixel`=`src_data` combinationally.
- Coordinates: a delayed copy of (y,x) tags each strobe.
- Interior writes: for a strobe of pixel (r,c) with r≥2 and c≥2, capture `filt_pixel_out` in the next cycle and register it.
  - `dst_wr_en`=1, `dst_addr`=(r−1)·W+(c−1), `dst_data`=`filt_pixel_out`.
  - The write is visible two cycles after the strobe.
  - No write is issued for r<2 or c<2.
- DRAIN: 3 cycles, ending in the cycle the last interior write is visible. `hold` is ignored.
- Next state after DRAIN: BORDER if the macro is compiled in, otherwise DONE.
- DONE: `done`=1 for one cycle, `frame_cnt` increments, → IDLE.
- `abort`, in any non-IDLE state: next cycle is IDLE.
  - `dst_wr_en`, `src_rd_en`, `filt_in_ready` and `filt_clr` are 0 from that cycle on.
  - In-flight writes are dropped. No `done` pulse, no count increment.
- `abort` takes priority over `start`.
- Address arithmetic is unsigned, ADDR_W bits. The multiply by W is an unrolled constant (counter plus row base register, not a multiplier).

## Timing
- Reset values: all outputs 0, `frame_cnt`=0, state IDLE.
- Notation: `start` sampled at edge k, N=W·H, no hold, macro off.
  - `filt_clr` high in cycle k+1.
  - Reads in cycles k+2 … k+N+1.
  - Strobes in cycles k+3 … k+N+2.
  - Last write visible in cycle k+N+4.
  - `done` in cycle k+N+5; `busy` low from k+N+6.
- Each `hold` cycle during READ delays every later event by one cycle.
- Throughput: one pixel per cycle; per-frame overhead is 5 cycles (plus BORDER).

## Configuration
- `EDGE_BORDER_ZERO_EN`
  - Defined: BORDER state lasts B+1 cycles, where B=2W+2H−4.
    - It issues one registered write per cycle with `dst_data`=0, in this order: row 0 x=0..W−1, row H−1 x=0..W−1, then for y=1..H−2 the pixels (y,0) and (y,W−1).
    - The last cycle issues nothing, so `done` is delayed by B+1 cycles.
  - Undefined: border pixels are never written and BORDER does not exist.

## Structure
- `edge_pkg` holds:
  - the state enum;
  - the pixel typedef `pix_t` (logic [3:0]);
  - the frame-count width constant;
  - the function for the border pixel count.
- Sub-module `border_addr_gen`: a counter that generates the border address sequence (start/step/last). It is instantiated only under `EDGE_BORDER_ZERO_EN`.

## Test plan
Unless stated otherwise, benches use W=8, H=6 and `start` at edge 0.
- Constant image 5, macro off:
  - exactly 24 writes, all with `dst_data`=0;
  - addresses are the interior pixels (y=1..4, x=1..6);
  - `done` in cycle 53; `frame_cnt`=1.
- Same stimulus, macro on:
  - 24 interior writes plus 24 border writes of 0, in the specified order;
  - `done` in cycle 78.
- Random image:
  - every `dst_data` matches a bit-accurate filter model at its centre address;
  - no address is written twice.
- `hold` high for cycles 10–14: `done` in cycle 58, and write data is identical to the unheld run.
- `abort` at cycle 30:
  - `busy` and `dst_wr_en` low from cycle 31;
  - no `done`, `frame_cnt` unchanged;
  - a following `start` produces a correct full frame.
- Back-to-back frames:
  - `start` during `busy` is ignored;
  - `start` after `done` produces `filt_clr` and a second correct frame;
  - `frame_cnt`=2.
